// File: rtl/mem_bus_arbiter.sv
// Shares the core memory bus between instruction fetch and the LSU. One transaction is outstanding at a time.
// The LSU has priority, a starvation counter bounds how long IF can be locked out, and flushed fetch responses are dropped.
module mem_bus_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  input  logic        instr_kill_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        bus_req_o,
  output logic [31:0] bus_addr_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_err_i
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID} state_e;
  typedef enum logic {OWN_DATA = 1'b0, OWN_INSTR = 1'b1} owner_e;

  state_e             state_q, state_d;
  owner_e             owner_q, owner_d;
  logic               kill_pend_q, kill_pend_d;
  logic [CNT_W-1:0]   starve_q, starve_d;

  logic   starve_hit;
  logic   instr_win;
  logic   any_req;
  logic   req_c;
  logic   grant_c;
  logic   kill_c;
  owner_e cur_owner;

  // Arbitration: in IDLE the winner is picked live, otherwise the latched owner holds the bus
  always_comb begin
    starve_hit = (starve_q == CNT_W'(STARVE_MAX));
    instr_win  = instr_req_i & (~data_req_i | starve_hit);
    any_req    = instr_req_i | data_req_i;
    cur_owner  = owner_q;
    if (state_q == IDLE) cur_owner = instr_win ? OWN_INSTR : OWN_DATA;
    req_c      = ((state_q == IDLE) & any_req) | (state_q == WAIT_GNT);
    grant_c    = req_c & bus_gnt_i;
    kill_c     = instr_kill_i & (owner_q == OWN_INSTR) & (state_q != IDLE);
  end

  // State and bookkeeping registers; reset abandons any transaction in flight
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_DATA;
      kill_pend_q <= 1'b0;
      starve_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      kill_pend_q <= kill_pend_d;
      starve_q    <= starve_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    kill_pend_d = kill_pend_q;
    starve_d    = starve_q;
    case (state_q)
      IDLE: begin
        kill_pend_d = 1'b0;
        if (any_req) begin
          owner_d = cur_owner;
          state_d = bus_gnt_i ? WAIT_RVALID : WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        if (kill_c)    kill_pend_d = 1'b1;
        if (bus_gnt_i) state_d = WAIT_RVALID;
      end
      WAIT_RVALID: begin
        if (bus_rvalid_i) begin
          state_d     = IDLE;
          kill_pend_d = 1'b0;
        end else if (kill_c) begin
          kill_pend_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!instr_req_i) begin
      starve_d = '0;
    end else if (grant_c && cur_owner == OWN_INSTR) begin
      starve_d = '0;
    end else if (grant_c && !starve_hit) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  // Outputs: bus request/attributes, grants and response routing
  always_comb begin
    instr_gnt_o    = 1'b0;
    instr_rvalid_o = 1'b0;
    instr_rdata_o  = '0;
    instr_err_o    = 1'b0;
    data_gnt_o     = 1'b0;
    data_rvalid_o  = 1'b0;
    data_rdata_o   = '0;
    data_err_o     = 1'b0;
    bus_req_o      = 1'b0;
    bus_addr_o     = '0;
    bus_we_o       = 1'b0;
    bus_be_o       = '0;
    bus_wdata_o    = '0;
    if (reset_n) begin
      if (req_c) begin
        bus_req_o = 1'b1;
        if (cur_owner == OWN_DATA) begin
          bus_addr_o  = data_addr_i;
          bus_we_o    = data_we_i;
          bus_be_o    = data_be_i;
          bus_wdata_o = data_wdata_i;
          data_gnt_o  = bus_gnt_i;
        end else begin
          bus_addr_o  = instr_addr_i;
          instr_gnt_o = bus_gnt_i;
        end
      end
      if (state_q == WAIT_RVALID && bus_rvalid_i) begin
        if (owner_q == OWN_DATA) begin
          data_rvalid_o = 1'b1;
          data_rdata_o  = bus_rdata_i;
          data_err_o    = bus_err_i;
        end else if (!(kill_pend_q || instr_kill_i)) begin
          instr_rvalid_o = 1'b1;
          instr_rdata_o  = bus_rdata_i;
          instr_err_o    = bus_err_i;
        end
      end
    end
  end

endmodule
